round_robin_arbiter: RTL



---
 rtl/round_robin_arbiter_pkg.sv | 9 +
 rtl/rr_grant_logic.sv | 41 ++++
 rtl/round_robin_arbiter.sv | 57 +++++
 3 files changed

// File: rtl/round_robin_arbiter_pkg.sv
// Shared helpers for the round-robin arbiter: index arithmetic with explicit wrap,
// so non-power-of-two input counts rotate correctly.
package round_robin_arbiter_pkg;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_grant_logic.sv
// Combinational round-robin grant: rotate requests by ptr, priority-encode the
// lowest set bit, then rotate the result back into absolute index space.
module rr_grant_logic #(
  parameter int p_ninputs = 4
) (
  input  logic [p_ninputs-1:0]         req,
  input  logic [$clog2(p_ninputs)-1:0] ptr,
  output logic [p_ninputs-1:0]         grant,
  output logic [$clog2(p_ninputs)-1:0] grant_idx,
  output logic                         any_req
);
  localparam int c_idx_w = $clog2(p_ninputs);

  logic [2*p_ninputs-1:0] dbl;
  logic [p_ninputs-1:0]   rot;
  logic [c_idx_w-1:0]     off;
  logic [c_idx_w:0]       sum;
  logic                   found;

  always_comb begin
    dbl     = {req, req} >> ptr;
    rot     = dbl[p_ninputs-1:0];
    any_req = |req;
    off     = '0;
    found   = 1'b0;
    for (int i = 0; i < p_ninputs; i++) begin
      if (!found && rot[i]) begin
        off   = c_idx_w'(i);
        found = 1'b1;
      end
    end
    // ptr + off can exceed p_ninputs-1 only by less than p_ninputs, so one subtract wraps it.
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (c_idx_w+1)'(p_ninputs))
      sum = sum - (c_idx_w+1)'(p_ninputs);
    grant_idx        = sum[c_idx_w-1:0];
    grant            = '0;
    grant[grant_idx] = any_req;
  end

endmodule

// File: rtl/round_robin_arbiter.sv
// Merges p_ninputs valid/ready streams into one registered stream, fairly by round robin.
// Handshake: a transfer happens on an edge where val && rdy; istream_val must not depend on istream_rdy.
module round_robin_arbiter
  import round_robin_arbiter_pkg::*;
#(
  parameter int p_nbits   = 32,
  parameter int p_ninputs = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [p_ninputs-1:0]         istream_val,
  input  logic [p_nbits-1:0]           istream_msg [p_ninputs-1:0],
  output logic [p_ninputs-1:0]         istream_rdy,
  output logic                         ostream_val,
  output logic [p_nbits-1:0]           ostream_msg,
  output logic [$clog2(p_ninputs)-1:0] ostream_src,
  input  logic                         ostream_rdy
);
  localparam int c_idx_w = $clog2(p_ninputs);

  logic [c_idx_w-1:0]   ptr;
  logic [p_ninputs-1:0] grant;
  logic [c_idx_w-1:0]   grant_idx;
  logic                 any_req;
  logic                 load_en;
  logic                 fire_in;

  rr_grant_logic #(.p_ninputs(p_ninputs)) grant_logic (
    .req       (istream_val),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  // Reset gating keeps senders from believing a message was taken on the reset edge.
  assign load_en     = (!ostream_val || ostream_rdy) && !reset;
  assign fire_in     = load_en && any_req;
  assign istream_rdy = load_en ? grant : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      ostream_val <= 1'b0;
      ostream_msg <= '0;
      ostream_src <= '0;
      ptr         <= '0;
    end else if (fire_in) begin
      ostream_val <= 1'b1;
      ostream_msg <= istream_msg[grant_idx];
      ostream_src <= grant_idx;
      ptr         <= c_idx_w'(wrap_inc(int'(grant_idx), p_ninputs));
    end else if (ostream_rdy) begin
      ostream_val <= 1'b0;
    end
  end

endmodule
